// File: rtl/slave_rx_port_p.sv
// Serial receive port for bus slaves: LSB-first address/data deserialiser with write and read bursts.
// Optional even-parity bit after write data when PARITY_EN is defined; otherwise parity_err is tied low.
module slave_rx_port_p #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 8,
    parameter int BURST_W = 12,
    parameter int RD_GAP  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_addr,
    input  logic               rx_data,
    input  logic               master_valid,
    input  logic               master_ready,
    input  logic               write_en,
    input  logic               read_en,
    input  logic               burst_en,
    input  logic [BURST_W-1:0] burst_len,
    output logic               slave_ready,
    output logic [ADDR_W-1:0]  addr_out,
    output logic [DATA_W-1:0]  data_out,
    output logic               rx_done,
    output logic               wr_beat,
    output logic [BURST_W-1:0] burst_count,
    output logic               parity_err
);

`ifdef PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int DS_BITS = DATA_W + PAR_W;
    localparam int WR_BITS = (ADDR_W > DS_BITS) ? ADDR_W : DS_BITS;
    localparam int MAX_CNT = (WR_BITS > RD_GAP) ? WR_BITS : RD_GAP;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);

    typedef enum logic [2:0] {IDLE, SHIFT, BEAT, WAIT_HS, DSHIFT, RGAP} state_t;

    state_t             state;
    logic               is_wr;
    logic               is_burst;
    logic [BURST_W-1:0] len_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic               hs_start;
    logic               hs_beat;

    // Valid/ready: a transfer happens on a clock edge where master_valid and slave_ready are both 1.
    // A start handshake with neither write_en nor read_en carries no transaction and is ignored.
    assign hs_beat  = master_valid & slave_ready;
    assign hs_start = hs_beat & (write_en | read_en);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            slave_ready <= 1'b0;
            addr_out    <= '0;
            data_out    <= '0;
            rx_done     <= 1'b0;
            wr_beat     <= 1'b0;
            burst_count <= '0;
            parity_err  <= 1'b0;
            is_wr       <= 1'b0;
            is_burst    <= 1'b0;
            len_q       <= '0;
            bit_cnt     <= '0;
        end else begin
            rx_done     <= 1'b0;
            wr_beat     <= 1'b0;
            slave_ready <= (state == IDLE) || (state == WAIT_HS);
            case (state)
                IDLE: begin
                    if (hs_start) begin
                        is_wr       <= write_en;
                        is_burst    <= burst_en;
                        len_q       <= burst_len;
                        burst_count <= '0;
                        parity_err  <= 1'b0;
                        bit_cnt     <= '0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    for (int i = 0; i < ADDR_W; i++)
                        if (bit_cnt == CNT_W'(i)) addr_out[i] <= rx_addr;
                    if (is_wr)
                        for (int i = 0; i < DATA_W; i++)
                            if (bit_cnt == CNT_W'(i)) data_out[i] <= rx_data;
`ifdef PARITY_EN
                    if (is_wr && bit_cnt == CNT_W'(DATA_W) && (rx_data != ^data_out))
                        parity_err <= 1'b1;
`endif
                    if (bit_cnt == (is_wr ? CNT_W'(WR_BITS - 1) : CNT_W'(ADDR_W - 1))) begin
                        rx_done <= 1'b1;
                        wr_beat <= is_wr;
                        bit_cnt <= '0;
                        state   <= BEAT;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                BEAT: begin
                    bit_cnt <= '0;
                    if (!is_burst || burst_count == len_q) state <= IDLE;
                    else if (is_wr)                         state <= WAIT_HS;
                    else                                    state <= RGAP;
                end
                WAIT_HS: begin
                    if (hs_beat) begin
                        bit_cnt <= '0;
                        state   <= DSHIFT;
                    end
                end
                DSHIFT: begin
                    for (int i = 0; i < DATA_W; i++)
                        if (bit_cnt == CNT_W'(i)) data_out[i] <= rx_data;
`ifdef PARITY_EN
                    if (bit_cnt == CNT_W'(DATA_W) && (rx_data != ^data_out))
                        parity_err <= 1'b1;
`endif
                    if (bit_cnt == CNT_W'(DS_BITS - 1)) begin
                        addr_out    <= addr_out + 1'b1;
                        burst_count <= burst_count + 1'b1;
                        rx_done     <= 1'b1;
                        wr_beat     <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= BEAT;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                RGAP: begin
                    // Fixed gap first, then hold until the master can take the beat.
                    if (bit_cnt != CNT_W'(RD_GAP)) begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end else if (master_ready) begin
                        addr_out    <= addr_out + 1'b1;
                        burst_count <= burst_count + 1'b1;
                        rx_done     <= 1'b1;
                        bit_cnt     <= '0;
                        state       <= BEAT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slave_rx_port_p.sv
// Directed + randomized bench for slave_rx_port_p with an expected-beat queue model.
// Build with PARITY_EN defined to also exercise the parity bit.
module tb_slave_rx_port_p;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int BW  = 12;
    localparam int GAP = 8;
`ifdef PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    localparam int WRN = (AW > DW + PW) ? AW : DW + PW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_addr = 1'b0, rx_data = 1'b0;
    logic          master_valid = 1'b0, master_ready = 1'b1;
    logic          write_en = 1'b0, read_en = 1'b0, burst_en = 1'b0;
    logic [BW-1:0] burst_len = '0;
    logic          slave_ready, rx_done, wr_beat, parity_err;
    logic [AW-1:0] addr_out;
    logic [DW-1:0] data_out;
    logic [BW-1:0] burst_count;

    int tests = 0;
    int fails = 0;
    logic [AW+DW:0] exp_q[$];   // {wr, addr, data} per expected beat
    logic [DW-1:0]  last_data = '0;
    logic           exp_perr = 1'b0;

    slave_rx_port_p #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .RD_GAP(GAP)) dut (
        .clk(clk), .reset(reset), .rx_addr(rx_addr), .rx_data(rx_data),
        .master_valid(master_valid), .master_ready(master_ready),
        .write_en(write_en), .read_en(read_en), .burst_en(burst_en), .burst_len(burst_len),
        .slave_ready(slave_ready), .addr_out(addr_out), .data_out(data_out),
        .rx_done(rx_done), .wr_beat(wr_beat), .burst_count(burst_count), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (slave_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("ready_seen", {31'd0, slave_ready}, 32'd1);
    endtask

    task automatic handshake(input logic wr, input logic rd, input logic bst, input logic [BW-1:0] len);
        wait_ready();
        master_valid = 1'b1; write_en = wr; read_en = rd; burst_en = bst; burst_len = len;
        tick();
        master_valid = 1'b0;
        exp_perr = 1'b0;
        // Mode inputs are don't-care once the transaction has started.
        write_en = 1'($urandom); read_en = 1'($urandom);
        burst_en = 1'($urandom); burst_len = BW'($urandom);
    endtask

    task automatic push_exp(input logic wr, input int addr, input logic [DW-1:0] data);
        logic [AW-1:0] a;
        a = AW'(addr % (1 << AW));
        if (wr) last_data = data;
        exp_q.push_back({wr, a, wr ? data : last_data});
    endtask

    // First beat: address (and data for writes) shifted after the start handshake.
    task automatic shift_first(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                               input logic bad_par);
        int n;
        n = wr ? WRN : AW;
        push_exp(wr, int'(addr), data);
        if (wr && PW == 1 && bad_par) exp_perr = 1'b1;
        for (int i = 0; i < n; i++) begin
            rx_addr = (i < AW) ? addr[i] : 1'($urandom);
            if (wr && i < DW)       rx_data = data[i];
            else if (wr && i == DW) rx_data = (^data) ^ bad_par;
            else                    rx_data = 1'($urandom);
            if (i == n - 1) check("done_early", {31'd0, rx_done}, 32'd0);
            tick();
        end
    endtask

    task automatic shift_data(input logic [DW-1:0] data, input logic bad_par);
        if (PW == 1 && bad_par) exp_perr = 1'b1;
        for (int i = 0; i < DW + PW; i++) begin
            rx_addr = 1'($urandom);
            rx_data = (i < DW) ? data[i] : ((^data) ^ bad_par);
            tick();
        end
    endtask

    task automatic check_beat(input int cnt);
        logic [AW+DW:0] e;
        check("queue_has_beat", {31'd0, exp_q.size() != 0}, 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check("rx_done", {31'd0, rx_done}, 32'd1);
        check("wr_beat", {31'd0, wr_beat}, {31'd0, e[AW+DW]});
        check("addr_out", {20'd0, addr_out}, {20'd0, e[AW+DW-1:DW]});
        check("data_out", {24'd0, data_out}, {24'd0, e[DW-1:0]});
        check("burst_count", {20'd0, burst_count}, cnt);
        check("parity_err", {31'd0, parity_err}, {31'd0, exp_perr});
    endtask

    task automatic end_txn();
        tick();
        check("done_pulse_len", {31'd0, rx_done}, 32'd0);
    endtask

    task automatic write_txn(input logic rd, input int start, input int len, input logic wtog);
        logic [DW-1:0] d;
        d = DW'($urandom);
        handshake(1'b1, rd, len != 0, BW'(len));
        shift_first(1'b1, AW'(start), d, 1'b0);
        check_beat(0);
        for (int b = 1; b <= len; b++) begin
            end_txn();
            wait_ready();
            master_valid = 1'b1;
            if (wtog) begin write_en = 1'b0; read_en = 1'b1; end
            tick();
            master_valid = 1'b0;
            d = DW'($urandom);
            push_exp(1'b1, start + b, d);
            shift_data(d, 1'b0);
            check_beat(b);
        end
        end_txn();
    endtask

    task automatic read_txn(input int start, input int len);
        int t, k;
        handshake(1'b0, 1'b1, len != 0, BW'(len));
        shift_first(1'b0, AW'(start), '0, 1'b0);
        check_beat(0);
        for (int b = 1; b <= len; b++) begin
            k = (b == 1) ? 5 : $urandom_range(0, 3);
            push_exp(1'b0, start + b, '0);
            if (k > 0) master_ready = 1'b0;
            t = 0;
            do begin
                tick();
                t++;
                if (t == GAP + 1 + k) master_ready = 1'b1;
            end while (rx_done !== 1'b1 && t < 100);
            master_ready = 1'b1;
            check("rd_interval", t, GAP + 2 + k);
            check_beat(b);
        end
        end_txn();
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        check("rst_ready", {31'd0, slave_ready}, 32'd0);
        check("rst_addr", {20'd0, addr_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_done", {30'd0, rx_done, wr_beat}, 32'd0);
        check("rst_cnt_perr", {19'd0, burst_count, parity_err}, 32'd0);
        reset = 1'b0;
        tick();
        check("ready_after_rst", {31'd0, slave_ready}, 32'd1);

        // Single write 0xA5C / 0x3C, rx_done exactly handshake+WRN
        handshake(1'b1, 1'b0, 1'b0, '0);
        shift_first(1'b1, 12'hA5C, 8'h3C, 1'b0);
        check_beat(0);
        end_txn();

        // Write burst of 4 beats from 0x010, with write_en toggled mid-burst
        write_txn(1'b0, 'h010, 3, 1'b1);

        // Read burst from 0xFFF wrapping, second beat delayed by 5 cycles
        read_txn('hFFF, 2);

        // write_en and read_en both set: write wins
        write_txn(1'b1, 'h123, 0, 1'b0);

        // Single non-burst read keeps previous write data
        read_txn('h456, 0);

        // Reset in the middle of a shift
        handshake(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) begin
            rx_addr = 1'($urandom); rx_data = 1'($urandom);
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_ready", {31'd0, slave_ready}, 32'd0);
        check("mid_rst_outs", {8'd0, addr_out, data_out, rx_done, wr_beat, parity_err, 1'b0}, 32'd0);
        check("mid_rst_cnt", {20'd0, burst_count}, 32'd0);
        last_data = '0;
        tick();
        check("mid_rst_ready1", {31'd0, slave_ready}, 32'd1);
        check("mid_rst_nodone", {31'd0, rx_done}, 32'd0);
        handshake(1'b1, 1'b0, 1'b0, '0);
        shift_first(1'b1, 12'h0F1, 8'hE7, 1'b0);
        check_beat(0);
        end_txn();

`ifdef PARITY_EN
        // Bad parity on 0x07 is sticky until the next start handshake
        handshake(1'b1, 1'b0, 1'b0, '0);
        shift_first(1'b1, 12'h222, 8'h07, 1'b1);
        check_beat(0);
        end_txn();
        tick();
        check("perr_sticky", {31'd0, parity_err}, 32'd1);
        handshake(1'b1, 1'b0, 1'b0, '0);
        check("perr_cleared", {31'd0, parity_err}, 32'd0);
        shift_first(1'b1, 12'h333, 8'h07, 1'b0);
        check_beat(0);
        end_txn();
`endif

        // Randomized transactions
        for (int n = 0; n < 8; n++) begin
            if ($urandom_range(0, 1) == 1)
                write_txn(1'($urandom), int'($urandom_range(0, 4095)), int'($urandom_range(0, 3)), 1'($urandom));
            else
                read_txn(int'($urandom_range(4090, 4095)), int'($urandom_range(0, 3)));
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
